bip_cpu_core: RTL and testbench

- Parametrised single-cycle BIP accumulator processor core: program counter, accumulator, instruction decoder and control unit in one block.
- Drives the program memory address and the data memory address, data, read strobe and write strobe.
- Successor to the fixed-width BIP register block. Adds conditional and unconditional branches, AND, a sticky halt state, a stall enable and a cycle counter.
- Program and data memories sit outside the block; both are combinational-read; data memory writes are synchronous.

---
 rtl/bip_cpu_core.sv | 186 ++++++++++++++++++
 tb/tb_bip_cpu_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_cpu_core.sv
// ---------------------------------------------------------------------------
// bip_cpu_core
//
// Single-cycle BIP accumulator processor core. Holds the program counter,
// the accumulator, a RUN/HALT state and a saturating executed-instruction
// counter. Program and data memories are external and combinational-read;
// data memory writes are synchronous and qualified by o_WrRam.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              asynchronous active-low reset
//   i_enable           1 = execute one instruction this cycle, 0 = stall
//   i_instruc          instruction fetched from o_addr_program_mem
//   i_data_memory      data read from o_addr_data_mem
//   o_addr_program_mem program counter
//   o_addr_data_mem    operand used as data address
//   o_data_memory      accumulator, used as store data
//   o_WrRam / o_RdRam  data memory write / read strobes
//   o_acc              accumulator value
//   o_halt             core has executed HLT
//   o_cycle_count      executed-instruction counter (saturating)
// ---------------------------------------------------------------------------
module bip_cpu_core #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16,
    parameter int NB_CNT     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [NB_INSTRUC-1:0] i_instruc,
    input  logic [NB_DATA-1:0]    i_data_memory,
    output logic [NB_ADDR-1:0]    o_addr_program_mem,
    output logic [NB_ADDR-1:0]    o_addr_data_mem,
    output logic [NB_DATA-1:0]    o_data_memory,
    output logic                  o_WrRam,
    output logic                  o_RdRam,
    output logic [NB_DATA-1:0]    o_acc,
    output logic                  o_halt,
    output logic [NB_CNT-1:0]     o_cycle_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
    localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'(8);
    localparam logic [NB_OPCODE-1:0] OP_ANDI = NB_OPCODE'(9);
    localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(10);
    localparam logic [NB_OPCODE-1:0] OP_BEQZ = NB_OPCODE'(11);
    localparam logic [NB_OPCODE-1:0] OP_BNEG = NB_OPCODE'(12);

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   pc_q, pc_d;
    logic [NB_DATA-1:0]   acc_q, acc_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic                 halt_q, halt_d;

    logic [NB_OPCODE-1:0]  opcode;
    logic [NB_OPERAND-1:0] operand;
    logic [NB_DATA-1:0]    imm;
    logic [NB_ADDR-1:0]    operand_addr;
    logic                  exec;
    logic                  wr_ram;
    logic                  rd_ram;
    logic                  unused_instruc_bits;

    assign opcode  = i_instruc[NB_INSTRUC-1 -: NB_OPCODE];
    assign operand = i_instruc[NB_OPERAND-1:0];

    // Operand bits beyond the address/immediate width are legitimately ignored.
    assign unused_instruc_bits = ^i_instruc;

    // Immediate: sign-extend a narrow operand, truncate a wide one.
    generate
        if (NB_OPERAND >= NB_DATA) begin : g_imm_trunc
            assign imm = operand[NB_DATA-1:0];
        end else begin : g_imm_sext
            assign imm = {{(NB_DATA-NB_OPERAND){operand[NB_OPERAND-1]}}, operand};
        end
    endgenerate

    // Address (data address and branch target): zero-extend or truncate.
    generate
        if (NB_OPERAND >= NB_ADDR) begin : g_addr_trunc
            assign operand_addr = operand[NB_ADDR-1:0];
        end else begin : g_addr_zext
            assign operand_addr = {{(NB_ADDR-NB_OPERAND){1'b0}}, operand};
        end
    endgenerate

    // Gating on i_rst keeps both strobes low while reset is held, even though
    // the state already reads RUN during reset.
    assign exec = i_rst && (state_q == ST_RUN) && i_enable;

    // Next-state decode for one executed instruction.
    always_comb begin
        pc_d    = pc_q;
        acc_d   = acc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;
        if (exec) begin
            if (cnt_q != {NB_CNT{1'b1}}) begin
                cnt_d = cnt_q + NB_CNT'(1);
            end
            pc_d = pc_q + NB_ADDR'(1);
            case (opcode)
                OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                OP_STO:  wr_ram = 1'b1;
                OP_LD: begin
                    rd_ram = 1'b1;
                    acc_d  = i_data_memory;
                end
                OP_LDI:  acc_d = imm;
                OP_ADD: begin
                    rd_ram = 1'b1;
                    acc_d  = acc_q + i_data_memory;
                end
                OP_ADDI: acc_d = acc_q + imm;
                OP_SUB: begin
                    rd_ram = 1'b1;
                    acc_d  = acc_q - i_data_memory;
                end
                OP_SUBI: acc_d = acc_q - imm;
                OP_AND: begin
                    rd_ram = 1'b1;
                    acc_d  = acc_q & i_data_memory;
                end
                OP_ANDI: acc_d = acc_q & imm;
                OP_JMP:  pc_d = operand_addr;
                OP_BEQZ: begin
                    if (acc_q == '0) pc_d = operand_addr;
                end
                OP_BNEG: begin
                    if (acc_q[NB_DATA-1]) pc_d = operand_addr;
                end
                default: ;
            endcase
        end
        halt_d = (state_d == ST_HALT);
    end

    // All architectural state, including the registered halt flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    assign o_addr_program_mem = pc_q;
    assign o_addr_data_mem    = operand_addr;
    assign o_data_memory      = acc_q;
    assign o_WrRam            = wr_ram;
    assign o_RdRam            = rd_ram;
    assign o_acc              = acc_q;
    assign o_halt             = halt_q;
    assign o_cycle_count      = cnt_q;

endmodule

// File: tb/tb_bip_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_bip_cpu_core
//
// Self-checking bench for bip_cpu_core. A default-parameter core runs
// directed programs and randomized programs against an instruction-level
// reference model; a second core with NB_DATA=32, NB_ADDR=8 covers
// parameter-dependent sign extension, target truncation and PC wrap.
// ---------------------------------------------------------------------------
module tb_bip_cpu_core;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] instruc;
   logic [15:0] rdData;
   logic [10:0] pcOut;
   logic [10:0] dAddr;
   logic [15:0] wData;
   logic        wrRam;
   logic        rdRam;
   logic [15:0] accOut;
   logic        haltOut;
   logic [31:0] cntOut;

   logic        enable2;
   logic [15:0] instruc2;
   logic [7:0]  pcOut2;
   logic [7:0]  dAddr2;
   logic [31:0] wData2;
   logic        wrRam2;
   logic        rdRam2;
   logic [31:0] accOut2;
   logic        haltOut2;
   logic [31:0] cntOut2;

   logic [15:0] prog  [2048];
   logic [15:0] dmem  [2048];
   logic [15:0] prog2 [256];

   int          testCount;
   int          failCount;

   int          mPc;
   int          mAcc;
   longint      mCnt;
   bit          mHalt;
   int          mMem [2048];

   bip_cpu_core dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_enable           (enable),
      .i_instruc          (instruc),
      .i_data_memory      (rdData),
      .o_addr_program_mem (pcOut),
      .o_addr_data_mem    (dAddr),
      .o_data_memory      (wData),
      .o_WrRam            (wrRam),
      .o_RdRam            (rdRam),
      .o_acc              (accOut),
      .o_halt             (haltOut),
      .o_cycle_count      (cntOut)
   );

   bip_cpu_core #(
      .NB_INSTRUC (16),
      .NB_OPCODE  (5),
      .NB_OPERAND (11),
      .NB_ADDR    (8),
      .NB_DATA    (32),
      .NB_CNT     (32)
   ) dut32 (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_enable           (enable2),
      .i_instruc          (instruc2),
      .i_data_memory      (32'h0),
      .o_addr_program_mem (pcOut2),
      .o_addr_data_mem    (dAddr2),
      .o_data_memory      (wData2),
      .o_WrRam            (wrRam2),
      .o_RdRam            (rdRam2),
      .o_acc              (accOut2),
      .o_halt             (haltOut2),
      .o_cycle_count      (cntOut2)
   );

   // Combinational-read program and data memories.
   assign instruc  = prog[pcOut];
   assign rdData   = dmem[dAddr];
   assign instruc2 = prog2[pcOut2];

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input int op, input int opnd);
      logic [4:0]  o;
      logic [10:0] a;
      o = op[4:0];
      a = opnd[10:0];
      return {o, a};
   endfunction

   // Instruction-level reference: executes one instruction on model state.
   task automatic modelStep(input logic [15:0] ir);
      int op;
      int opnd;
      int imm;
      int nextPc;
      op   = int'(ir[15:11]);
      opnd = int'(ir[10:0]);
      imm  = (opnd >= 1024) ? opnd - 2048 : opnd;
      if (mCnt != 64'hFFFF_FFFF) mCnt = mCnt + 1;
      nextPc = (mPc + 1) % 2048;
      case (op)
         0:  begin mHalt = 1'b1; nextPc = mPc; end
         1:  mMem[opnd] = mAcc;
         2:  mAcc = mMem[opnd];
         3:  mAcc = imm & 65535;
         4:  mAcc = (mAcc + mMem[opnd]) % 65536;
         5:  mAcc = (mAcc + imm + 65536) % 65536;
         6:  mAcc = (mAcc - mMem[opnd] + 65536) % 65536;
         7:  mAcc = (mAcc - imm + 65536) % 65536;
         8:  mAcc = mAcc & mMem[opnd];
         9:  mAcc = mAcc & (imm & 65535);
         10: nextPc = opnd;
         11: if (mAcc == 0) nextPc = opnd;
         12: if (mAcc >= 32768) nextPc = opnd;
         default: ;
      endcase
      mPc = nextPc;
   endtask

   // One clock cycle: starts and ends just after a falling edge.
   task automatic applyStimulus(input logic en);
      logic [15:0] ir;
      bit          ex;
      bit          isRd;
      logic        capWr;
      logic [10:0] capAddr;
      logic [15:0] capData;
      int          op;
      enable = en;
      #1;
      ir   = prog[mPc];
      op   = int'(ir[15:11]);
      ex   = !mHalt && en;
      isRd = (op == 2) || (op == 4) || (op == 6) || (op == 8);
      checkOutput("pc",     64'(pcOut),   64'(mPc));
      checkOutput("acc",    64'(accOut),  64'(mAcc));
      checkOutput("count",  64'(cntOut),  64'(mCnt));
      checkOutput("halt",   64'(haltOut), 64'(mHalt));
      checkOutput("wrRam",  64'(wrRam),   64'(ex && op == 1));
      checkOutput("rdRam",  64'(rdRam),   64'(ex && isRd));
      checkOutput("dAddr",  64'(dAddr),   64'(ir[10:0]));
      checkOutput("wData",  64'(wData),   64'(mAcc));
      capWr   = wrRam;
      capAddr = dAddr;
      capData = wData;
      @(posedge clk);
      if (capWr) dmem[capAddr] = capData;
      if (ex) modelStep(ir);
      @(negedge clk);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases.
   task automatic doReset();
      enable = 1'b1;
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_pc",    64'(pcOut),   64'h0);
      checkOutput("rst_acc",   64'(accOut),  64'h0);
      checkOutput("rst_count", 64'(cntOut),  64'h0);
      checkOutput("rst_halt",  64'(haltOut), 64'h0);
      checkOutput("rst_wr",    64'(wrRam),   64'h0);
      checkOutput("rst_rd",    64'(rdRam),   64'h0);
      checkOutput("rst_pc32",  64'(pcOut2),  64'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_hold_pc",  64'(pcOut),  64'h0);
      checkOutput("rst_hold_acc", 64'(accOut), 64'h0);
      @(negedge clk);
      rst   = 1'b1;
      mPc   = 0;
      mAcc  = 0;
      mCnt  = 0;
      mHalt = 1'b0;
   endtask

   task automatic clearProg();
      for (int i = 0; i < 2048; i++) prog[i] = 16'hF800 | 16'($urandom_range(0, 2047));
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      rst       = 1'b0;
      enable    = 1'b0;
      enable2   = 1'b0;
      for (int i = 0; i < 256; i++) prog2[i] = 16'hF800;
      prog2[0]    = ins(3, 'h400);
      prog2[1]    = ins(10, 'h1FF);
      prog2[8'hFF] = ins(31, 0);
      for (int i = 0; i < 2048; i++) begin
         dmem[i] = 16'($urandom);
         mMem[i] = int'(dmem[i]);
      end
      clearProg();
      @(negedge clk);

      // LDI 5; ADDI -2; STO 0x010; HLT, then stay halted.
      $display("[TB] program: ldi/addi/sto/hlt");
      prog[0] = ins(3, 5);
      prog[1] = ins(5, 'h7FE);
      prog[2] = ins(1, 'h010);
      prog[3] = ins(0, 0);
      doReset();
      for (int i = 0; i < 14; i++) applyStimulus(1'b1);
      checkOutput("halt_pc",    64'(pcOut),       64'h3);
      checkOutput("halt_count", 64'(cntOut),      64'h4);
      checkOutput("halt_flag",  64'(haltOut),     64'h1);
      checkOutput("sto_mem",    64'(dmem['h010]), 64'h3);

      // LD / ADD wrap, SUBI, ANDI.
      $display("[TB] program: arithmetic wrap");
      clearProg();
      dmem['h020] = 16'h7FFF;
      mMem['h020] = 'h7FFF;
      prog[0] = ins(2, 'h020);
      prog[1] = ins(4, 'h020);
      prog[2] = ins(7, 1);
      prog[3] = ins(9, 'h00F);
      prog[4] = ins(0, 0);
      doReset();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("add_wrap", 64'(accOut), 64'hFFFE);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("andi", 64'(accOut), 64'h000D);
      applyStimulus(1'b1);

      // Branches and PC wrap.
      $display("[TB] program: branches");
      clearProg();
      prog[0]      = ins(3, 0);
      prog[1]      = ins(11, 'h040);
      prog['h040]  = ins(3, 1);
      prog['h041]  = ins(11, 0);
      prog['h042]  = ins(3, 'h7FF);
      prog['h043]  = ins(12, 'h7FF);
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1);
      checkOutput("bneg_pc", 64'(pcOut), 64'h7FF);
      applyStimulus(1'b1);
      checkOutput("wrap_pc", 64'(pcOut), 64'h0);

      // Stall across a store.
      $display("[TB] program: stall on store");
      clearProg();
      dmem['h011] = 16'h0;
      mMem['h011] = 0;
      prog[0] = ins(3, 7);
      prog[1] = ins(1, 'h011);
      prog[2] = ins(0, 0);
      doReset();
      applyStimulus(1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0);
      checkOutput("stall_nowrite", 64'(dmem['h011]), 64'h0);
      checkOutput("stall_count",   64'(cntOut),      64'h1);
      applyStimulus(1'b1);
      checkOutput("stall_write", 64'(dmem['h011]), 64'h7);
      applyStimulus(1'b1);

      // Wide-data / narrow-address core.
      $display("[TB] parameter variant: 32-bit data, 8-bit address");
      doReset();
      enable  = 1'b0;
      enable2 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("p32_ldi",   64'(accOut2), 64'hFFFF_FC00);
      checkOutput("p32_pc1",   64'(pcOut2),  64'h1);
      @(posedge clk);
      #1;
      checkOutput("p32_jmp",   64'(pcOut2),  64'hFF);
      @(posedge clk);
      #1;
      checkOutput("p32_nop",   64'(pcOut2),  64'h0);
      checkOutput("p32_count", 64'(cntOut2), 64'h3);
      @(negedge clk);
      enable2 = 1'b0;

      // Random programs with random stalls; each round ends in a
      // mid-program reset.
      $display("[TB] random programs");
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 2048; i++) begin
            int op;
            op = int'($urandom_range(0, 31));
            if (op == 0 && $urandom_range(0, 19) != 0) op = 3;
            if (op > 12 && $urandom_range(0, 3) != 0) op = int'($urandom_range(1, 12));
            prog[i] = ins(op, int'($urandom_range(0, 2047)));
            dmem[i] = 16'($urandom);
            mMem[i] = int'(dmem[i]);
         end
         doReset();
         for (int c = 0; c < 60; c++) applyStimulus($urandom_range(0, 3) != 0);
      end
      doReset();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
